// File: rtl/tt_sweep_capture_if.sv
// Bundle for the sweep/capture block. The master side drives the function
// inputs and presents the result; the slave side supplies f_in, start/abort
// and accepts the result.
interface tt_sweep_capture_if;
  logic         start;
  logic         abort;
  logic         busy;
  logic         x0;
  logic         x1;
  logic         x2;
  logic         x3;
  logic         x4;
  logic         x5;
  logic         x6;
  logic         f_in;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] tt;
  logic [7:0]   ones;

  modport master (
    input  start, abort, f_in, res_ready,
    output busy, x0, x1, x2, x3, x4, x5, x6, res_valid, tt, ones
  );

  modport slave (
    output start, abort, f_in, res_ready,
    input  busy, x0, x1, x2, x3, x4, x5, x6, res_valid, tt, ones
  );
endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps a 7-input combinational block through all 128 input vectors in
// ascending order, captures its truth table plus onset size, and hands the
// result out on a valid/ready port.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; last accepted table still presented
//   DRIVE  | x0..x6 = idx, letting the function settle for SETTLE+1 cycles
//   SAMPLE | capture f_in into tt[idx], accumulate ones
//   DONE   | res_valid high, table frozen until res_ready
module tt_sweep_capture #(
  parameter int SETTLE = 1,
  parameter int ONES_W = 8
) (
  input logic              clk,
  input logic              rst,
  tt_sweep_capture_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [1:0]        state_q;
  logic [6:0]        idx_q;
  logic [3:0]        cnt_q;
  logic [127:0]      tt_q;
  logic [ONES_W-1:0] ones_q;
  logic              sweeping;
  logic [6:0]        x_drv;

  // Sequencer: vector stepping, capture, abort and result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 7'd0;
      cnt_q   <= 4'd0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= DRIVE;
            idx_q   <= 7'd0;
            cnt_q   <= 4'd0;
            tt_q    <= '0;
            ones_q  <= '0;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            tt_q    <= '0;
            ones_q  <= '0;
          end else if (cnt_q == SETTLE_C) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          // Abort wins even on the final vector, so no partial result escapes.
          if (bus.abort) begin
            state_q <= IDLE;
            tt_q    <= '0;
            ones_q  <= '0;
          end else begin
            tt_q[idx_q] <= bus.f_in;
            ones_q      <= ones_q + ONES_W'(bus.f_in);
            if (idx_q == 7'd127) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 7'd1;
              cnt_q   <= 4'd0;
              state_q <= DRIVE;
            end
          end
        end
        default: begin
          if (bus.res_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state; x0..x6 only carry idx while sweeping.
  always_comb begin
    sweeping = (state_q == DRIVE) || (state_q == SAMPLE);
    x_drv    = sweeping ? idx_q : 7'd0;
  end

  assign bus.busy      = sweeping;
  assign bus.res_valid = (state_q == DONE);
  assign bus.tt        = tt_q;
  assign bus.ones      = ones_q;
  assign bus.x0        = x_drv[0];
  assign bus.x1        = x_drv[1];
  assign bus.x2        = x_drv[2];
  assign bus.x3        = x_drv[3];
  assign bus.x4        = x_drv[4];
  assign bus.x5        = x_drv[5];
  assign bus.x6        = x_drv[6];

endmodule
